cpu_result_collector: RTL and testbench

- Sits directly downstream of the cpu top level and consumes its out_pc, out_instruction and result_* outputs.
- Arms on a start pulse and counts run cycles. Detects program halt as the PC holding steady for a set number of edges, with a cycle timeout as backstop.
- On halt or timeout, snapshots the results and streams them word by word over a valid/ready handshake to a host or UART bridge.

---
 rtl/cpu_result_collector_if.sv | 25 ++
 rtl/cpu_result_collector.sv | 180 ++++++++++++++++++
 tb/tb_cpu_result_collector.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_result_collector_if.sv
// Result stream from cpu_result_collector to a host or UART bridge.
// The collector drives the word, index and last flag; the sink drives in_ready.
interface cpu_result_collector_if;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_index;
  logic        out_last;
  logic        in_ready;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  in_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output in_ready
  );
endinterface

// File: rtl/cpu_result_collector.sv
// Watches the cpu PC for a halt (or a cycle timeout), then streams the result frame.
// Define RESULT_TRACE_CHECKSUM_EN to append a rotate-xor checksum of executed instructions.
module cpu_result_collector #(
  parameter int unsigned HALT_CYCLES    = 8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  input  logic                          in_start,
  input  logic [31:0]                   in_pc,
  input  logic [31:0]                   in_instruction,
  input  logic [31:0]                   in_attempt_count,
  input  logic [31:0]                   in_broken_count,
  input  logic [31:0]                   in_material_cost,
  input  logic [31:0]                   in_human_cost,
  input  logic                          in_is_last_broken,
  cpu_result_collector_if.master        bus,
  output logic                          out_busy,
  output logic                          out_done,
  output logic                          out_timeout,
  output logic [31:0]                   out_cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SEND, S_DONE} state_t;

`ifdef RESULT_TRACE_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif
  localparam logic [31:0] HALT_LAST    = 32'(HALT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

  state_t      state;
  logic [31:0] cycle_count;
  logic [31:0] prev_pc;
  logic [31:0] stable_cnt;
  logic [31:0] snap_attempt;
  logic [31:0] snap_broken;
  logic [31:0] snap_material;
  logic [31:0] snap_human;
  logic        snap_last_broken;
  logic        valid_q;
  logic [31:0] data_q;
  logic [2:0]  index_q;
  logic        last_q;
  logic        done_q;
  logic        timeout_q;

`ifdef RESULT_TRACE_CHECKSUM_EN
  logic [31:0] csum;
  logic [31:0] csum_next;
  assign csum_next = {csum[30:0], csum[31]} ^ in_instruction;
`else
  logic unused_instruction;
  assign unused_instruction = ^in_instruction;
`endif

  logic        pc_equal;
  logic        halt_hit;
  logic        timeout_hit;
  logic [31:0] cycle_next;
  logic [2:0]  next_index;
  logic [31:0] next_word;

  assign pc_equal    = (in_pc == prev_pc);
  assign halt_hit    = pc_equal && (stable_cnt == HALT_LAST);
  assign timeout_hit = (cycle_count == TIMEOUT_LAST);
  assign cycle_next  = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
  assign next_index  = index_q + 3'd1;

  // Word that follows the one currently presented; everything it reads is frozen in SEND.
  always_comb begin
    next_word = '0;
    case (next_index)
      3'd0: next_word = snap_attempt;
      3'd1: next_word = snap_broken;
      3'd2: next_word = snap_material;
      3'd3: next_word = snap_human;
      3'd4: next_word = {31'b0, snap_last_broken};
      3'd5: next_word = cycle_count;
`ifdef RESULT_TRACE_CHECKSUM_EN
      3'd6: next_word = csum;
`endif
      default: next_word = '0;
    endcase
  end

  // NOTE: every register below updates with <= so all of them see the pre-edge values
  // of each other; a blocking assignment here would leak new values within the same edge.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      // NOTE: the snapshot registers are cleared too, so nothing from an aborted run
      // can ever be observed after reset.
      state            <= S_IDLE;
      cycle_count      <= '0;
      prev_pc          <= '0;
      stable_cnt       <= '0;
      snap_attempt     <= '0;
      snap_broken      <= '0;
      snap_material    <= '0;
      snap_human       <= '0;
      snap_last_broken <= 1'b0;
      valid_q          <= 1'b0;
      data_q           <= '0;
      index_q          <= '0;
      last_q           <= 1'b0;
      done_q           <= 1'b0;
      timeout_q        <= 1'b0;
`ifdef RESULT_TRACE_CHECKSUM_EN
      csum             <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (in_start) begin
            state       <= S_RUN;
            cycle_count <= '0;
            stable_cnt  <= '0;
            prev_pc     <= in_pc;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
`ifdef RESULT_TRACE_CHECKSUM_EN
            csum        <= '0;
`endif
          end
        end

        S_RUN: begin
          cycle_count <= cycle_next;
          prev_pc     <= in_pc;
          stable_cnt  <= pc_equal ? stable_cnt + 32'd1 : '0;
`ifdef RESULT_TRACE_CHECKSUM_EN
          csum        <= csum_next;
`endif
          if (halt_hit || timeout_hit) begin
            // Halt takes priority, so the timeout flag is only set for a pure timeout.
            state            <= S_SEND;
            timeout_q        <= !halt_hit;
            snap_attempt     <= in_attempt_count;
            snap_broken      <= in_broken_count;
            snap_material    <= in_material_cost;
            snap_human       <= in_human_cost;
            snap_last_broken <= in_is_last_broken;
            valid_q          <= 1'b1;
            data_q           <= in_attempt_count;
            index_q          <= '0;
            last_q           <= 1'b0;
          end
        end

        S_SEND: begin
          if (valid_q && bus.in_ready) begin
            if (index_q == LAST_IDX) begin
              state   <= S_DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              index_q <= next_index;
              data_q  <= next_word;
              last_q  <= (next_index == LAST_IDX);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_data    = data_q;
  assign bus.out_index   = index_q;
  assign bus.out_last    = last_q;
  assign out_busy        = (state == S_RUN) || (state == S_SEND);
  assign out_done        = done_q;
  assign out_timeout     = timeout_q;
  assign out_cycle_count = cycle_count;

endmodule

// File: tb/tb_cpu_result_collector.sv
// Self-checking bench for cpu_result_collector: table of runs (halt, timeout, tie, stalls)
// plus a reset-abort sequence; expected words go through a scoreboard queue.
module tb_cpu_result_collector;

  localparam int unsigned HALT = 4;
  localparam logic [31:0] TMO  = 32'd20;
`ifdef RESULT_TRACE_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc = '0, instr = '0;
  logic [31:0] attempt = '0, broken = '0, material = '0, human = '0;
  logic        lb = 1'b0;
  logic        busy, done, tmo_flag;
  logic [31:0] ccount;

  cpu_result_collector_if bus_if ();

  always #5 clk = ~clk;

  cpu_result_collector #(.HALT_CYCLES(HALT), .TIMEOUT_CYCLES(TMO)) dut (
    .in_clk            (clk),
    .in_rst            (rst),
    .in_start          (start),
    .in_pc             (pc),
    .in_instruction    (instr),
    .in_attempt_count  (attempt),
    .in_broken_count   (broken),
    .in_material_cost  (material),
    .in_human_cost     (human),
    .in_is_last_broken (lb),
    .bus               (bus_if),
    .out_busy          (busy),
    .out_done          (done),
    .out_timeout       (tmo_flag),
    .out_cycle_count   (ccount)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  idx;
    logic        last;
  } word_t;

  typedef struct {
    logic [31:0] base_pc;
    int          changes;
    logic [31:0] attempt, broken, material, human;
    logic        lb;
    int          ready_mode;   // 0: always ready, 1: pattern 1,0,0 repeating
    bit          noise;        // pulse in_start during RUN and SEND
    logic [31:0] seed;
    logic [31:0] exp_count;
    logic        exp_tmo;
  } vec_t;

  word_t exp_q[$];
  vec_t  rows[6];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted word is popped and compared; stalled words must hold.
  logic        stall_pending = 1'b0;
  logic [31:0] stall_data;
  logic [2:0]  stall_idx;
  always @(negedge clk) begin
    word_t w;
    if (mon_en && rst) begin
      if (stall_pending && bus_if.out_valid) begin
        check("hold_data", bus_if.out_data, stall_data);
        check("hold_index", 32'(bus_if.out_index), 32'(stall_idx));
      end
      if (bus_if.out_valid && bus_if.in_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got index %0d data %h expected no word", bus_if.out_index, bus_if.out_data);
        end else begin
          w = exp_q.pop_front();
          check("word_data", bus_if.out_data, w.data);
          check("word_index", 32'(bus_if.out_index), 32'(w.idx));
          check("word_last", 32'(bus_if.out_last), 32'(w.last));
        end
      end
      stall_pending = bus_if.out_valid && !bus_if.in_ready;
      stall_data    = bus_if.out_data;
      stall_idx     = bus_if.out_index;
    end else begin
      stall_pending = 1'b0;
    end
  end

  // Arm, step the PC through the run, and queue the expected frame before the stop edge.
  task automatic arm_and_run(input vec_t v);
    logic [31:0] csum;
    start    = 1'b1;
    pc       = v.base_pc;
    instr    = '0;
    attempt  = v.attempt;
    broken   = v.broken;
    material = v.material;
    human    = v.human;
    lb       = v.lb;
    tick();
    start = 1'b0;
    check("arm_busy", 32'(busy), 32'd1);
    check("arm_done", 32'(done), 32'd0);
    check("arm_timeout", 32'(tmo_flag), 32'd0);
    check("arm_count", ccount, 32'd0);
    csum = '0;
    for (int k = 1; k <= int'(v.exp_count); k++) begin
      pc    = (k <= v.changes) ? v.base_pc + 32'(4 * k) : v.base_pc + 32'(4 * v.changes);
      instr = v.seed + 32'(k) * 32'h0101_0101;
      csum  = {csum[30:0], csum[31]} ^ instr;
      start = v.noise && (k == 2);
      if (k == int'(v.exp_count)) begin
        exp_q.push_back('{v.attempt,  3'd0, 1'b0});
        exp_q.push_back('{v.broken,   3'd1, 1'b0});
        exp_q.push_back('{v.material, 3'd2, 1'b0});
        exp_q.push_back('{v.human,    3'd3, 1'b0});
        exp_q.push_back('{{31'b0, v.lb}, 3'd4, 1'b0});
        exp_q.push_back('{v.exp_count, 3'd5, LAST_IDX == 3'd5});
`ifdef RESULT_TRACE_CHECKSUM_EN
        exp_q.push_back('{csum, 3'd6, 1'b1});
`endif
      end
      tick();
      start = 1'b0;
      if (k == 1) check("run_count_first", ccount, 32'd1);
      if (k == int'(v.exp_count) - 1) begin
        check("run_valid_before_stop", 32'(bus_if.out_valid), 32'd0);
        check("run_count_live", ccount, v.exp_count - 32'd1);
      end
    end
    check("send_valid", 32'(bus_if.out_valid), 32'd1);
    check("send_busy", 32'(busy), 32'd1);
    check("send_timeout", 32'(tmo_flag), 32'(v.exp_tmo));
  endtask

  // Drain the frame under the row's ready pattern while the cpu inputs keep moving.
  task automatic drain(input vec_t v);
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      bus_if.in_ready = (v.ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      start    = v.noise && !(bus_if.out_valid && bus_if.out_last && bus_if.in_ready);
      attempt  = ~v.attempt;
      broken   = ~v.broken;
      material = ~v.material;
      human    = ~v.human;
      lb       = ~v.lb;
      pc       = pc + 32'd4;
      instr    = ~instr;
      tick();
    end
    start = 1'b0;
    check("done_flag", 32'(done), 32'd1);
    check("done_valid", 32'(bus_if.out_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("done_timeout", 32'(tmo_flag), 32'(v.exp_tmo));
    check("done_count", ccount, v.exp_count);
    check("words_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // base, changes, attempt, broken, material, human, lb, ready_mode, noise, seed, exp_count, exp_tmo
    rows[0] = '{32'h0000_0000,  8, 32'd7, 32'd2, 32'd5, 32'd9, 1'b1, 0, 1'b0, 32'h0, 32'd12, 1'b0};
    rows[1] = '{32'h0000_0100, 30, 32'd11, 32'd22, 32'd33, 32'd44, 1'b0, 0, 1'b1, 32'h10, 32'd20, 1'b1};
    rows[2] = '{32'h0000_0200, 16, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd3, 1'b1, 0, 1'b0, 32'h55, 32'd20, 1'b0};
    rows[3] = '{32'h0000_0300,  3, 32'hA5A5_A5A5, 32'd4, 32'd8, 32'd16, 1'b0, 1, 1'b1, 32'h77, 32'd7, 1'b0};
    rows[4] = '{32'h0000_0400,  0, 32'd5, 32'd6, 32'd7, 32'd8, 1'b1, 1, 1'b0, 32'h99, 32'd4, 1'b0};
    rows[5] = '{32'h0000_0500, 17, 32'd9, 32'd9, 32'd9, 32'd9, 1'b0, 0, 1'b0, 32'h3, 32'd20, 1'b1};

    bus_if.in_ready = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_data", bus_if.out_data, 32'd0);
    check("rst_index", 32'(bus_if.out_index), 32'd0);
    check("rst_last", 32'(bus_if.out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(tmo_flag), 32'd0);
    check("rst_count", ccount, 32'd0);
    rst = 1'b1;
    mon_en = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    for (int r = 0; r < 6; r++) begin
      arm_and_run(rows[r]);
      drain(rows[r]);
    end

    // Reset while index 2 is on the bus aborts the frame.
    arm_and_run(rows[0]);
    bus_if.in_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && bus_if.out_index != 3'd2; cyc++) tick();
    check("abort_index", 32'(bus_if.out_index), 32'd2);
    bus_if.in_ready = 1'b0;
    rst = 1'b0;
    tick();
    check("abort_valid", 32'(bus_if.out_valid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", ccount, 32'd0);
    check("abort_index_clr", 32'(bus_if.out_index), 32'd0);
    exp_q.delete();
    rst = 1'b1;
    tick();
    check("abort_idle_busy", 32'(busy), 32'd0);
    arm_and_run(rows[3]);
    drain(rows[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
